upower_decode_queue: RTL and testbench

- Registered successor to the combinational uPower field splitter.
- Accepts fetched 32-bit instructions with their PC over a valid/ready handshake.
- Classifies each instruction into a format and extracts its fields. Also produces a sign-extended immediate and a branch target.
- Buffers decoded entries in a DEPTH-entry FIFO feeding the execute stage. A synchronous flush discards everything in flight on redirect.

---
 rtl/upower_decode_queue.sv | 202 ++++++++++++++++++++
 tb/tb_upower_decode_queue.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upower_decode_queue.sv
// uPower decode queue: classifies fetched instructions, extracts their fields,
// immediate and branch target, and buffers the decoded entries in a small FIFO.
module upower_decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_fmt,
    output logic [5:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rt,
    output logic [4:0]                 out_bo,
    output logic [4:0]                 out_bi,
    output logic                       out_aa,
    output logic                       out_lk,
    output logic                       out_rc,
    output logic                       out_oe,
    output logic [9:0]                 out_xo,
    output logic [1:0]                 out_xods,
    output logic [XLEN-1:0]            out_imm,
    output logic [XLEN-1:0]            out_target,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_XO = 3'd0;
    localparam logic [2:0] FMT_X  = 3'd1;
    localparam logic [2:0] FMT_D  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_I  = 3'd4;
    localparam logic [2:0] FMT_DS = 3'd5;

    typedef struct packed {
        logic [2:0]      fmt;
        logic [5:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      bo;
        logic [4:0]      bi;
        logic            aa;
        logic            lk;
        logic            rc;
        logic            oe;
        logic [9:0]      xo;
        logic [1:0]      xods;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    logic [5:0]      opcode;
    logic [8:0]      xo9;
    logic [XLEN-1:0] imm_d16, imm_b14, imm_i24;

    assign opcode  = in_instr[31:26];
    assign xo9     = in_instr[9:1];
    assign imm_d16 = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
    assign imm_b14 = {{(XLEN-16){in_instr[15]}}, in_instr[15:2], 2'b00};
    assign imm_i24 = {{(XLEN-26){in_instr[25]}}, in_instr[25:2], 2'b00};

    always_comb begin
        dec        = '0;
        dec.opcode = opcode;
        dec.pc     = in_pc;
        if (opcode == 6'd31 && (xo9 == 9'd266 || xo9 == 9'd40)) begin
            dec.fmt = FMT_XO;
        end else if (opcode == 6'd31) begin
            dec.fmt = FMT_X;
        end else if (opcode inside {6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
                                    6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44}) begin
            dec.fmt = FMT_D;
        end else if (opcode == 6'd19) begin
            dec.fmt = FMT_B;
        end else if (opcode == 6'd18) begin
            dec.fmt = FMT_I;
        end else begin
            dec.fmt = FMT_DS;
        end

        case (dec.fmt)
            FMT_XO, FMT_X: begin
                dec.rd = in_instr[25:21];
                dec.rs = in_instr[20:16];
                dec.rt = in_instr[15:11];
                dec.rc = in_instr[0];
                if (dec.fmt == FMT_XO) begin
                    dec.oe = in_instr[10];
                    dec.xo = {1'b0, xo9};
                end else begin
                    dec.xo = in_instr[10:1];
                end
            end
            FMT_D: begin
                dec.rd  = in_instr[25:21];
                dec.rs  = in_instr[20:16];
                dec.imm = imm_d16;
            end
            FMT_B: begin
                dec.bo  = in_instr[25:21];
                dec.bi  = in_instr[20:16];
                dec.aa  = in_instr[1];
                dec.lk  = in_instr[0];
                dec.imm = imm_b14;
            end
            FMT_I: begin
                dec.aa  = in_instr[1];
                dec.lk  = in_instr[0];
                dec.imm = imm_i24;
            end
            default: begin
                dec.rd   = in_instr[25:21];
                dec.rs   = in_instr[20:16];
                dec.xods = in_instr[1:0];
                dec.imm  = imm_b14;
            end
        endcase

        // Absolute branches take the immediate as-is; relative ones wrap around XLEN.
        if (dec.fmt == FMT_B || dec.fmt == FMT_I) begin
            dec.target = dec.aa ? dec.imm : in_pc + dec.imm;
        end
    end

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is never reset; the empty-queue gating below hides stale data.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign out_fmt    = head.fmt;
    assign out_opcode = head.opcode;
    assign out_rd     = head.rd;
    assign out_rs     = head.rs;
    assign out_rt     = head.rt;
    assign out_bo     = head.bo;
    assign out_bi     = head.bi;
    assign out_aa     = head.aa;
    assign out_lk     = head.lk;
    assign out_rc     = head.rc;
    assign out_oe     = head.oe;
    assign out_xo     = head.xo;
    assign out_xods   = head.xods;
    assign out_imm    = head.imm;
    assign out_target = head.target;
    assign out_pc     = head.pc;
    assign count      = count_q;

endmodule

// File: tb/tb_upower_decode_queue.sv
// Bench for upower_decode_queue: a scoreboard of independently decoded entries
// is filled on accepted pushes and checked against the head on every pop.
module tb_upower_decode_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic        aa;
        logic        lk;
        logic        rc;
        logic        oe;
        logic [9:0]  xo;
        logic [1:0]  xods;
        logic [63:0] imm;
        logic [63:0] target;
        logic [63:0] pc;
    } entry_t;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic [2:0]  out_fmt;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rd, out_rs, out_rt, out_bo, out_bi;
    logic        out_aa, out_lk, out_rc, out_oe;
    logic [9:0]  out_xo;
    logic [1:0]  out_xods;
    logic [63:0] out_imm, out_target, out_pc;
    logic [2:0]  count;

    entry_t dut_e;
    entry_t sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    logic   last_push;

    upower_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fmt(out_fmt), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_bo(out_bo), .out_bi(out_bi),
        .out_aa(out_aa), .out_lk(out_lk), .out_rc(out_rc), .out_oe(out_oe),
        .out_xo(out_xo), .out_xods(out_xods),
        .out_imm(out_imm), .out_target(out_target), .out_pc(out_pc),
        .count(count)
    );

    assign dut_e = {out_fmt, out_opcode, out_rd, out_rs, out_rt, out_bo, out_bi,
                    out_aa, out_lk, out_rc, out_oe, out_xo, out_xods,
                    out_imm, out_target, out_pc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder written straight from the instruction-format tables.
    function automatic entry_t model(input logic [31:0] ins, input logic [63:0] pc);
        entry_t e;
        logic [5:0] op;
        logic [8:0] x9;
        e = '0;
        op = ins[31:26];
        x9 = ins[9:1];
        e.opcode = op;
        e.pc = pc;
        if (op == 6'd31) begin
            e.rd = ins[25:21]; e.rs = ins[20:16]; e.rt = ins[15:11]; e.rc = ins[0];
            if (x9 == 9'd266 || x9 == 9'd40) begin
                e.fmt = 3'd0; e.oe = ins[10]; e.xo = 10'(x9);
            end else begin
                e.fmt = 3'd1; e.xo = ins[10:1];
            end
        end else if (op inside {6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
                                6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44}) begin
            e.fmt = 3'd2; e.rd = ins[25:21]; e.rs = ins[20:16];
            e.imm = 64'($signed(ins[15:0]));
        end else if (op == 6'd19) begin
            e.fmt = 3'd3; e.bo = ins[25:21]; e.bi = ins[20:16]; e.aa = ins[1]; e.lk = ins[0];
            e.imm = 64'($signed({ins[15:2], 2'b00}));
            e.target = e.aa ? e.imm : pc + e.imm;
        end else if (op == 6'd18) begin
            e.fmt = 3'd4; e.aa = ins[1]; e.lk = ins[0];
            e.imm = 64'($signed({ins[25:2], 2'b00}));
            e.target = e.aa ? e.imm : pc + e.imm;
        end else begin
            e.fmt = 3'd5; e.rd = ins[25:21]; e.rs = ins[20:16]; e.xods = ins[1:0];
            e.imm = 64'($signed({ins[15:2], 2'b00}));
        end
        return e;
    endfunction

    // One clock: check status against the model, score any pop, record any push.
    task automatic step();
        logic do_push, do_pop;
        @(negedge clk);
        n_checks++;
        if (in_ready !== (sb.size() != DEPTH)) begin
            n_fail++; $display("FAIL in_ready: got %0b want %0b", in_ready, sb.size() != DEPTH);
        end
        n_checks++;
        if (out_valid !== (sb.size() != 0)) begin
            n_fail++; $display("FAIL out_valid: got %0b want %0b", out_valid, sb.size() != 0);
        end
        n_checks++;
        if (count !== 3'(sb.size())) begin
            n_fail++; $display("FAIL count: got %0d want %0d", count, sb.size());
        end
        if (sb.size() == 0) begin
            n_checks++;
            if (dut_e !== '0) begin
                n_fail++; $display("FAIL empty_outputs: got %h want 0", dut_e);
            end
        end
        do_push = in_valid && (sb.size() != DEPTH) && !flush;
        do_pop  = out_ready && (sb.size() != 0) && !flush;
        if (do_pop) begin
            n_checks++;
            if (dut_e !== sb[0]) begin
                n_fail++; $display("FAIL pop_entry: got %h want %h", dut_e, sb[0]);
            end
            $display("pop   pc=%h fmt=%0d", out_pc, out_fmt);
            void'(sb.pop_front());
        end
        if (flush) sb.delete();
        if (do_push) begin
            sb.push_back(model(in_instr, in_pc));
            $display("push  instr=%h pc=%h", in_instr, in_pc);
        end
        last_push = do_push;
        @(posedge clk);
        #1;
    endtask

    task automatic push_single(input logic [31:0] ins, input logic [63:0] pc);
        in_instr = ins; in_pc = pc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_single();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 || dut_e !== '0) begin
            n_fail++; $display("FAIL reset_state: got v=%0b r=%0b c=%0d want v=0 r=1 c=0", out_valid, in_ready, count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_d_form();
        push_single(32'h3861FFFC, 64'h100);
        n_checks++;
        if (out_valid !== 1'b1 || out_fmt !== 3'd2 || out_rd !== 5'd3 || out_rs !== 5'd1 ||
            out_imm !== 64'hFFFFFFFFFFFFFFFC || out_target !== 64'd0 || count !== 3'd1) begin
            n_fail++; $display("FAIL d_form: got v=%0b fmt=%0d rd=%0d rs=%0d imm=%h tgt=%h c=%0d want 1 2 3 1 fffffffffffffffc 0 1",
                               out_valid, out_fmt, out_rd, out_rs, out_imm, out_target, count);
        end
        pop_single();
    endtask

    task automatic test_xo_form();
        push_single(32'h7CA63A14, 64'h200);
        n_checks++;
        if (out_fmt !== 3'd0 || out_rd !== 5'd5 || out_rs !== 5'd6 || out_rt !== 5'd7 ||
            out_xo !== 10'd266 || out_oe !== 1'b0 || out_rc !== 1'b0 || out_imm !== 64'd0) begin
            n_fail++; $display("FAIL xo_form: got fmt=%0d rd=%0d rs=%0d rt=%0d xo=%0d oe=%0b rc=%0b imm=%h want 0 5 6 7 266 0 0 0",
                               out_fmt, out_rd, out_rs, out_rt, out_xo, out_oe, out_rc, out_imm);
        end
        pop_single();
    endtask

    task automatic test_i_form();
        push_single(32'h4BFFFFF8, 64'h100);
        n_checks++;
        if (out_fmt !== 3'd4 || out_aa !== 1'b0 || out_lk !== 1'b0 ||
            out_imm !== 64'hFFFFFFFFFFFFFFF8 || out_target !== 64'hF8) begin
            n_fail++; $display("FAIL i_rel: got fmt=%0d aa=%0b lk=%0b imm=%h tgt=%h want 4 0 0 fffffffffffffff8 f8",
                               out_fmt, out_aa, out_lk, out_imm, out_target);
        end
        pop_single();
        push_single(32'h4BFFFFFA, 64'h100);
        n_checks++;
        if (out_aa !== 1'b1 || out_target !== 64'hFFFFFFFFFFFFFFF8) begin
            n_fail++; $display("FAIL i_abs: got aa=%0b tgt=%h want 1 fffffffffffffff8", out_aa, out_target);
        end
        pop_single();
    endtask

    task automatic test_backpressure();
        logic [31:0] prog [5];
        int idx, guard;
        prog[0] = 32'h38210008; prog[1] = 32'h7C0802A6; prog[2] = 32'h41820010;
        prog[3] = 32'hE8410018; prog[4] = 32'h7C632050;
        idx = 0; guard = 0;
        out_ready = 1'b0;
        while (idx < 4 && guard < 20) begin
            in_instr = prog[idx]; in_pc = 64'h1000 + 64'(idx * 4); in_valid = 1'b1;
            step();
            if (last_push) idx++;
            guard++;
        end
        n_checks++;
        if (idx != 4 || count !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full: got accepted=%0d c=%0d r=%0b want 4 4 0", idx, count, in_ready);
        end
        in_instr = prog[4]; in_pc = 64'h1010;
        repeat (2) step();
        n_checks++;
        if (last_push !== 1'b0) begin
            n_fail++; $display("FAIL held_5th: got accepted=%0b want 0", last_push);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (last_push !== 1'b0) begin
            n_fail++; $display("FAIL pop_when_full: got accepted=%0b want 0", last_push);
        end
        step();
        n_checks++;
        if (last_push !== 1'b1 || count !== 3'd3) begin
            n_fail++; $display("FAIL accept_after_pop: got accepted=%0b c=%0d want 1 3", last_push, count);
        end
        in_valid = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 2 * DEPTH) begin
            step(); guard++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL drain_timeout: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_flush();
        push_single(32'h38600001, 64'h40);
        push_single(32'h38600002, 64'h44);
        in_instr = 32'h38600003; in_pc = 64'h48;
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush: got c=%0d v=%0b want 0 0", count, out_valid);
        end
        step();
        push_single(32'h38600004, 64'h4C);
        pop_single();
    endtask

    task automatic test_async_reset();
        push_single(32'h38600011, 64'h80);
        push_single(32'h4800000C, 64'h84);
        push_single(32'h7C631A15, 64'h88);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 || dut_e !== '0) begin
            n_fail++; $display("FAIL async_reset: got v=%0b r=%0b c=%0d want 0 1 0", out_valid, in_ready, count);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        push_single(32'h4C000021, 64'h300);
        n_checks++;
        if (out_fmt !== 3'd3 || out_pc !== 64'h300 || count !== 3'd1) begin
            n_fail++; $display("FAIL post_reset_push: got fmt=%0d pc=%h c=%0d want 3 300 1", out_fmt, out_pc, count);
        end
        pop_single();
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [10];
        logic [31:0] ins;
        int guard;
        ops[0] = 6'd31; ops[1] = 6'd31; ops[2] = 6'd14; ops[3] = 6'd24; ops[4] = 6'd19;
        ops[5] = 6'd18; ops[6] = 6'd58; ops[7] = 6'd62; ops[8] = 6'd44; ops[9] = 6'd0;
        for (int i = 0; i < 80; i++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 9)];
            if (ins[31:26] == 6'd31 && $urandom_range(0, 1) == 1)
                ins[9:1] = ($urandom_range(0, 1) == 1) ? 9'd266 : 9'd40;
            in_instr  = ins;
            in_pc     = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 2 * DEPTH) begin
            step(); guard++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL final_drain: got left=%0d v=%0b want 0 0", sb.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_d_form();
        test_xo_form();
        test_i_form();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
